// File: rtl/seq_arb_pkg.sv
// seq_arb_pkg: shared state encoding, default parameters and helpers for seq_detect_arbiter
package seq_arb_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    localparam int N_DEF         = 4;
    localparam int FRAME_LEN_DEF = 8;
    localparam int PAT_W_DEF     = 3;
    localparam int CNT_W_DEF     = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction

    // first set request searching upward from ptr, wrapping at n (n <= 8)
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] r;
        logic f;
        int j;
        r = '0;
        f = 1'b0;
        for (int i = 0; i < 8; i++) begin
            j = (int'(ptr) + i) % n;
            if (!f && i < n && req[j]) begin
                r = 3'(j);
                f = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_arbiter_detector.sv
// pattern_detector: serial pattern matcher with history shift register and fill counter
// Ports: i_clk, i_rst_n (async active-low), i_clr (sync clear), i_valid/i_bit (serial sample),
//        i_pattern (MSB is oldest bit), o_match (combinational, this sample completes a match),
//        o_hit (registered pulse one cycle after the matching sample).
// Macro SEQ_ARB_OVERLAP_EN: defined keeps history after a match (overlapping matches);
//        undefined clears history and fill on a match so the completing bit is not reused.
module pattern_detector
    import seq_arb_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_match,
    output logic             o_hit
);

    logic [PAT_W-1:0] r_hist;
    logic [3:0]       r_fill;
    logic [PAT_W-1:0] w_hist_n;
    logic [3:0]       w_fill_n;

    assign w_hist_n = PAT_W'({r_hist, i_bit});
    assign w_fill_n = r_fill + 4'(r_fill < 4'(PAT_W));
    assign o_match  = i_valid && (w_fill_n >= 4'(PAT_W)) && (w_hist_n == i_pattern);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            o_hit  <= 1'b0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
            o_hit  <= 1'b0;
        end else begin
            o_hit <= o_match;
            if (i_valid) begin
`ifdef SEQ_ARB_OVERLAP_EN
                r_hist <= w_hist_n;
                r_fill <= w_fill_n;
`else
                r_hist <= o_match ? '0 : w_hist_n;
                r_fill <= o_match ? '0 : w_fill_n;
`endif
            end
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: round-robin sequencer sharing one pattern detector among N serial requesters
// Ports: i_clk, i_rst_n (async active-low), i_req[N] (level requests), i_din[N] (serial bits),
//        i_cfg_pattern (latched at grant), o_grant (one-hot, registered), o_busy (RUN or DONE),
//        o_hit (match pulse), o_done (frame end pulse), o_done_id / o_match_count (valid with
//        o_done, held until the next one).
// Macro SEQ_ARB_OVERLAP_EN selects overlapping match counting in the detector.
module seq_detect_arbiter
    import seq_arb_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ID_W      = clog2(N),
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int PAT_W     = PAT_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_din,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    output logic [N-1:0]     o_grant,
    output logic             o_busy,
    output logic             o_hit,
    output logic             o_done,
    output logic [ID_W-1:0]  o_done_id,
    output logic [CNT_W-1:0] o_match_count
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_rr;
    logic [ID_W-1:0]  r_idx;
    logic [7:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [PAT_W-1:0] r_pat;

    logic [ID_W-1:0]  w_pick;
    logic             w_start;
    logic             w_sample;
    logic             w_last;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_n;

    assign w_pick   = ID_W'(rr_pick(8'(i_req), 3'(r_rr), N));
    assign w_start  = (r_state == S_IDLE) && (|i_req);
    assign w_sample = (r_state == S_RUN);
    assign w_last   = w_sample && (r_bit_cnt == 8'(FRAME_LEN - 1));
    // the completing bit's match is folded in on the same edge so the last-bit hit is counted
    assign w_cnt_n  = (w_match && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    assign o_busy   = (r_state != S_IDLE);

    pattern_detector #(.PAT_W(PAT_W)) u_det (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_start),
        .i_valid  (w_sample),
        .i_bit    (i_din[r_idx]),
        .i_pattern(r_pat),
        .o_match  (w_match),
        .o_hit    (o_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_idx         <= '0;
            r_bit_cnt     <= '0;
            r_cnt         <= '0;
            r_pat         <= '0;
            o_grant       <= '0;
            o_done        <= 1'b0;
            o_done_id     <= '0;
            o_match_count <= '0;
        end else begin
            o_done <= w_last;
            if (w_start) begin
                r_state   <= S_RUN;
                r_idx     <= w_pick;
                o_grant   <= N'(1) << w_pick;
                r_pat     <= i_cfg_pattern;
                r_bit_cnt <= '0;
                r_cnt     <= '0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_cnt     <= w_cnt_n;
                if (w_last) begin
                    r_state       <= S_DONE;
                    o_grant       <= '0;
                    o_done_id     <= r_idx;
                    o_match_count <= w_cnt_n;
                    r_rr          <= (r_idx == ID_W'(N - 1)) ? '0 : r_idx + 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb_seq_detect_arbiter: directed frames with a done-driven scoreboard
module tb_seq_detect_arbiter;

    localparam int N  = 4;
    localparam int ID_W = 2;
    localparam int FL = 8;
    localparam int PW = 3;
    localparam int CW = 2;

`ifdef SEQ_ARB_OVERLAP_EN
    localparam int C1 = 3, H1 = 3, CZ = 3, HZ = 6;
`else
    localparam int C1 = 2, H1 = 2, CZ = 2, HZ = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  din = '0;
    logic [PW-1:0] pat = '0;
    logic [N-1:0]  o_grant;
    logic          o_busy, o_hit, o_done;
    logic [ID_W-1:0] o_done_id;
    logic [CW-1:0] o_match_count;

    seq_detect_arbiter #(.N(N), .FRAME_LEN(FL), .PAT_W(PW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_din(din), .i_cfg_pattern(pat),
        .o_grant(o_grant), .o_busy(o_busy), .o_hit(o_hit), .o_done(o_done),
        .o_done_id(o_done_id), .o_match_count(o_match_count)
    );

    always #5 clk = ~clk;

    typedef struct {int id; int cnt; int hits;} exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int hits_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) hits_seen = 0;
            else begin
                if (o_hit) hits_seen++;
                if (o_done) begin
                    if (q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("done_id", 32'(o_done_id), e.id);
                        chk("match_count", 32'(o_match_count), e.cnt);
                        chk("hit_pulses", hits_seen, e.hits);
                    end
                    hits_seen = 0;
                end
            end
        end
    end

    task automatic push(input int id, input int cnt, input int hits);
        exp_t e;
        e.id = id; e.cnt = cnt; e.hits = hits;
        q.push_back(e);
    endtask

    task automatic wait_grant(input logic [N-1:0] expg);
        int n = 0;
        while (o_grant == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(o_grant), 32'(expg));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_grant != '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("grant_release", 32'(o_grant), 0);
    endtask

    task automatic do_frame(input logic [N-1:0] expg, input int id, input logic [7:0] bits,
                            input bit drop, input bit chg);
        wait_grant(expg);
        for (int i = 0; i < FL; i++) begin
            din[id] = bits[i];
            if (i == 0 && drop) req = '0;
            if (i == 3 && chg) pat = 3'b111;
            @(negedge clk);
        end
        din = '0;
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_hit", 32'(o_hit), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_done_id", 32'(o_done_id), 0);
        chk("rst_match_count", 32'(o_match_count), 0);
        pat = 3'b010;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // round robin with req=1010 held
        push(1, 0, 0); push(3, 0, 0); push(1, 0, 0);
        req = 4'b1010;
        wait_grant(4'b0010);
        chk("busy_run", 32'(o_busy), 1);
        wait_idle();
        wait_grant(4'b1000);
        wait_idle();
        wait_grant(4'b0010);
        req = '0;
        wait_idle();
        repeat (3) @(negedge clk);

        // pattern 010 on requester 0
        push(0, C1, H1);
        req = 4'b0001;
        do_frame(4'b0001, 0, 8'h4A, 1'b0, 1'b0);
        chk("count_held", 32'(o_match_count), C1);
        chk("done_low", 32'(o_done), 0);

        // reset mid-frame at bit 4 of requester 1
        req = 4'b0010;
        wait_grant(4'b0010);
        for (int i = 0; i < 5; i++) begin
            din[1] = 1'b0;
            if (i < 4) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_grant", 32'(o_grant), 0);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_done", 32'(o_done), 0);
        req = 4'b0011;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        push(0, 0, 0);
        do_frame(4'b0001, 0, 8'h00, 1'b0, 1'b0);

        // req dropped and pattern changed mid-frame on requester 2
        pat = 3'b010;
        push(2, C1, H1);
        req = 4'b0100;
        do_frame(4'b0100, 2, 8'h4A, 1'b1, 1'b1);

        // saturation: pattern 000 over an all-zero frame on requester 3
        pat = 3'b000;
        push(3, CZ, HZ);
        req = 4'b1000;
        do_frame(4'b1000, 3, 8'h00, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
Round-robin controller that shares one programmable serial pattern detector among N requester bit streams. A requester wins a grant, then streams a fixed-length frame of serial bits. The controller clears the detector at frame start and counts pattern hits. At frame end it returns a per-frame match count tagged with the requester ID. It sits in front of the sequence-detection FSM family as its sequencer and scheduler.

Parameters:
N, 4, number of requesters (2..8)
ID_W, 2, width of requester index, equal to clog2(N)
FRAME_LEN, 8, bits per frame (>= PAT_W, <= 255)
PAT_W, 3, pattern length in bits (1..8)
CNT_W, 4, match counter width; saturating

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
req  in  N  per-requester frame request, level
din  in  N  per-requester serial data bit
cfg_pattern  in  PAT_W  pattern to detect, MSB is first bit received
grant  out  N  one-hot grant, registered
busy  out  1  high in RUN and DONE
hit  out  1  registered one-cycle pulse per counted match
done  out  1  one-cycle pulse at frame end
done_id  out  ID_W  requester served, valid with done
match_count  out  CNT_W  frame match total, valid with done, held until next done

Behaviour:
- Reset values: grant=0, busy=0, hit=0, done=0, done_id=0, match_count=0, state=IDLE, rr_ptr=0, history and counters cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: req sampled each edge. If any bit is set, pick the first set bit searching upward from rr_ptr, with wrap.
  - Register grant (one-hot) and latch cfg_pattern into pat_q.
  - Clear bit_cnt, history, fill and frame count; go to RUN.
- RUN: each edge samples din[granted index] into the detector and increments bit_cnt.
  - First sample occurs on the first edge with grant high. Requester drives bit 0 during the first grant cycle.
  - After sample FRAME_LEN-1, go to DONE.
- DONE: grant=0, done=1 for one cycle, done_id and match_count updated.
  - rr_ptr becomes (served index + 1) mod N.
  - Go to IDLE; a new grant is earliest on the edge after DONE.
- Latency: req seen at edge k gives grant from k+1, bit samples at edges k+1..k+FRAME_LEN, done during cycle after edge k+FRAME_LEN.
- req is ignored outside IDLE. Dropping req mid-frame does not abort; the frame completes with whatever din carries.
- Detector: shift register of the last PAT_W bits plus a fill counter.
  - A match requires fill >= PAT_W and history == pat_q.
  - hit pulses the cycle after the completing bit's edge. The last-bit hit coincides with done, and that match is included in match_count.
- Counting: frame counter saturates at 2^CNT_W-1; no wrap.
- cfg_pattern changes mid-frame have no effect; it is latched at grant.
- Reset low mid-frame: immediate return to reset values, no done, rr_ptr=0.
- Simultaneous requests: round-robin only; no starvation. Worst-case wait is (N-1) frames.

Optional Feature:
SEQ_ARB_OVERLAP_EN
- Defined: overlapping matches counted; history is kept after a match.
- Undefined: non-overlapping; history and fill are cleared on the edge a match is detected, and the completing bit is not reused.

Decomposition:
- Package seq_arb_pkg: state enum (IDLE, RUN, DONE), default parameter constants, a round-robin pick function, and a clog2 helper.
- One sub-module, pattern_detector: shift history, fill counter, compare, hit, clear input and overlap macro handling. The controller owns arbitration, framing and counting.

Test Plan:
- Overlap build, pattern 010, req=0001, din[0] stream 0,1,0,1,0,0,1,0 -> hits after bits 2,4,7; done_id=0, match_count=3.
- Non-overlap build, same stimulus -> hits after bits 2,7; match_count=2.
- After reset, req=1010 held -> grant=0010 first, done_id=1; then grant=1000, done_id=3; then grant=0010 again.
- Overlap build, CNT_W=2, pattern 000, all-zero frame of 8 -> 6 hits pulse, match_count saturates at 3.
- Reset low at bit 4 of a frame -> grant=0, busy=0 asynchronously, no done, next grant from rr_ptr=0.
- req dropped after grant, cfg_pattern changed mid-frame -> frame runs full FRAME_LEN, counts against the latched pattern, single done pulse.
